// File: rtl/audio_pdm_dac.sv
// Audio PDM DAC: first-order sigma-delta modulator with soft ramp,
// two-entry sample FIFO and underrun reporting.
module audio_pdm_dac #(
  parameter int unsigned OSR_DIV    = 1,
  parameter int unsigned SAMPLE_DIV = 256,
  parameter logic [15:0] RAMP_STEP  = 16'h0040
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [15:0] sample_i,
  input  logic        sample_valid_i,
  output logic        sample_ready_o,
  output logic        pdm_o,
  output logic        underrun_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RUN,
    RAMP_DOWN
  } state_e;

  localparam logic [15:0] MID       = 16'h8000;
  localparam logic [7:0]  CNT_LAST  = 8'(OSR_DIV - 1);
  localparam logic [15:0] SCNT_LAST = 16'(SAMPLE_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] scnt_q, scnt_d;
  logic [15:0] lvl_q, lvl_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] cur_q, cur_d;
  logic        pdm_q, pdm_d;
  logic [15:0] mem_q [2];
  logic [15:0] mem_d [2];
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [1:0]  count_q, count_d;

  logic        tick, due, push, pop;
  logic [15:0] eff, lvl_up, lvl_dn;
  logic [16:0] up_sum, mod_sum;

  assign tick    = cnt_q == CNT_LAST;
  assign due     = tick && state_q == RUN
                && scnt_q == SCNT_LAST;
  assign pop     = due && count_q != 2'd0;
  assign push    = sample_valid_i && sample_ready_o;

  assign sample_ready_o = state_q != IDLE
                       && count_q != 2'd2;
  assign underrun_o = due && count_q == 2'd0;
  assign busy_o     = state_q != IDLE;
  assign pdm_o      = pdm_q;

  assign eff     = (state_q == RUN) ? cur_q : lvl_q;
  assign mod_sum = {1'b0, acc_q} + {1'b0, eff};
  assign up_sum  = {1'b0, lvl_q} + {1'b0, RAMP_STEP};
  assign lvl_up  = (up_sum >= {1'b0, MID})
                 ? MID : up_sum[15:0];
  assign lvl_dn  = (lvl_q > RAMP_STEP)
                 ? lvl_q - RAMP_STEP : '0;

  // The level step is applied on the same tick that
  // changes direction, so a reversal never stalls.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_d = RAMP_UP;
            lvl_d   = lvl_up;
          end
        end
        RUN: begin
          if (!enable_i) begin
            lvl_d   = lvl_dn;
            state_d = (lvl_dn == '0)
                    ? IDLE : RAMP_DOWN;
          end
        end
        RAMP_UP, RAMP_DOWN: begin
          if (enable_i) begin
            lvl_d   = lvl_up;
            state_d = (lvl_up == MID)
                    ? RUN : RAMP_UP;
          end else begin
            lvl_d   = lvl_dn;
            state_d = (lvl_dn == '0)
                    ? IDLE : RAMP_DOWN;
          end
        end
      endcase
    end
  end

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + 8'd1;
    acc_d  = acc_q;
    pdm_d  = pdm_q;
    cur_d  = cur_q;
    scnt_d = scnt_q;
    if (state_q == IDLE) begin
      acc_d = '0;
      pdm_d = 1'b0;
    end else if (tick) begin
      {pdm_d, acc_d} = mod_sum;
    end
    if (tick && state_q == RUN) begin
      scnt_d = due ? '0 : scnt_q + 16'd1;
    end
    if (pop) begin
      cur_d = mem_q[rd_q];
    end
    if (state_d == RUN && state_q != RUN) begin
      cur_d  = MID;
      scnt_d = '0;
    end
  end

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (state_q == IDLE) begin
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = sample_i;
        wr_d        = ~wr_q;
      end
      if (pop) begin
        rd_d = ~rd_q;
      end
      count_d = count_q + {1'b0, push}
              - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      scnt_q  <= '0;
      lvl_q   <= '0;
      acc_q   <= '0;
      cur_q   <= MID;
      pdm_q   <= 1'b0;
      mem_q   <= '{default: '0};
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      lvl_q   <= lvl_d;
      acc_q   <= acc_d;
      cur_q   <= cur_d;
      pdm_q   <= pdm_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_audio_pdm_dac.sv
// Bench for audio_pdm_dac: two instances (default and OSR_DIV=3/SAMPLE_DIV=4)
// against a queue-based behavioural model, a vector table and directed cases.
module tb_audio_pdm_dac;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_RUN  = 2;
  localparam int M_DN   = 3;
  localparam int FULL   = 32768;

  int P_OSR  [2] = '{1, 3};
  int P_SDIV [2] = '{256, 4};
  int P_STEP [2] = '{64, 4096};

  logic        clk = 1'b0;
  logic        rst [2];
  logic        en  [2];
  logic        val [2];
  logic [15:0] smp [2];
  logic        rdy [2];
  logic        pdm [2];
  logic        und [2];
  logic        bsy [2];
  logic [15:0] lvl_p [2];
  logic [15:0] cur_p [2];

  int checks = 0;
  int errors = 0;

  int          m_st   [2];
  int          m_lvl  [2];
  int          m_acc  [2];
  int          m_cur  [2];
  int          m_div  [2];
  int          m_scnt [2];
  bit          m_pdm  [2];
  logic [15:0] m_q    [2][$];

  always #5 clk = ~clk;

  audio_pdm_dac u0 (
    .clk_i          (clk),
    .rst_i          (rst[0]),
    .enable_i       (en[0]),
    .sample_i       (smp[0]),
    .sample_valid_i (val[0]),
    .sample_ready_o (rdy[0]),
    .pdm_o          (pdm[0]),
    .underrun_o     (und[0]),
    .busy_o         (bsy[0])
  );

  audio_pdm_dac #(
    .OSR_DIV    (3),
    .SAMPLE_DIV (4),
    .RAMP_STEP  (16'h1000)
  ) u1 (
    .clk_i          (clk),
    .rst_i          (rst[1]),
    .enable_i       (en[1]),
    .sample_i       (smp[1]),
    .sample_valid_i (val[1]),
    .sample_ready_o (rdy[1]),
    .pdm_o          (pdm[1]),
    .underrun_o     (und[1]),
    .busy_o         (bsy[1])
  );

  assign lvl_p[0] = u0.lvl_q;
  assign cur_p[0] = u0.cur_q;
  assign lvl_p[1] = u1.lvl_q;
  assign cur_p[1] = u1.cur_q;

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h",
               nm, i, act, exp);
    end
  endtask

  function automatic void m_reset(int i);
    m_st[i]   = M_IDLE;
    m_lvl[i]  = 0;
    m_acc[i]  = 0;
    m_cur[i]  = FULL;
    m_div[i]  = 0;
    m_scnt[i] = 0;
    m_pdm[i]  = 1'b0;
    m_q[i].delete();
  endfunction

  function automatic bit m_tick(int i);
    return m_div[i] == P_OSR[i] - 1;
  endfunction

  function automatic bit m_rdy(int i);
    return m_st[i] != M_IDLE && m_q[i].size() < 2;
  endfunction

  function automatic bit m_und(int i);
    return m_tick(i) && m_st[i] == M_RUN
        && m_scnt[i] == P_SDIV[i] - 1
        && m_q[i].size() == 0;
  endfunction

  // One clock of the reference: ramp as saturating arithmetic,
  // modulator as integer accumulate with carry-out, FIFO as a queue.
  function automatic void m_step(int i, bit e, bit v,
                                 logic [15:0] s);
    bit t;
    bit psh;
    int eff, ns, nl, sum, up, dn;
    t   = m_tick(i);
    psh = v && m_rdy(i);
    eff = (m_st[i] == M_RUN) ? m_cur[i] : m_lvl[i];
    ns  = m_st[i];
    nl  = m_lvl[i];
    if (m_st[i] == M_IDLE) begin
      m_q[i].delete();
      m_acc[i] = 0;
      m_pdm[i] = 1'b0;
    end else if (t) begin
      sum      = m_acc[i] + eff;
      m_pdm[i] = sum >= 65536;
      m_acc[i] = sum % 65536;
    end
    if (t && m_st[i] == M_RUN) begin
      if (m_scnt[i] == P_SDIV[i] - 1) begin
        m_scnt[i] = 0;
        if (m_q[i].size() > 0)
          m_cur[i] = m_q[i].pop_front();
      end else begin
        m_scnt[i]++;
      end
    end
    if (t) begin
      up = m_lvl[i] + P_STEP[i];
      if (up > FULL) up = FULL;
      dn = m_lvl[i] - P_STEP[i];
      if (dn < 0) dn = 0;
      if (m_st[i] == M_IDLE) begin
        if (e) begin
          ns = M_UP;
          nl = up;
        end
      end else if (e && m_st[i] != M_RUN) begin
        nl = up;
        ns = (up == FULL) ? M_RUN : M_UP;
      end else if (!e) begin
        nl = dn;
        ns = (dn == 0) ? M_IDLE : M_DN;
      end
      if (ns == M_RUN && m_st[i] != M_RUN) begin
        m_cur[i]  = FULL;
        m_scnt[i] = 0;
      end
      m_st[i]  = ns;
      m_lvl[i] = nl;
    end
    if (psh) m_q[i].push_back(s);
    m_div[i] = t ? 0 : m_div[i] + 1;
  endfunction

  task automatic cyc();
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) m_reset(i);
      else m_step(i, en[i], val[i], smp[i]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("pdm", i, pdm[i], m_pdm[i]);
      chk("ready", i, rdy[i], m_rdy(i));
      chk("underrun", i, und[i], m_und(i));
      chk("busy", i, bsy[i], m_st[i] != M_IDLE);
      chk("lvl", i, lvl_p[i], m_lvl[i]);
      chk("cur", i, cur_p[i], m_cur[i]);
    end
  endtask

  typedef struct {
    bit          en;
    int          n;
    bit          busy;
    bit          ready;
    logic [15:0] lvl;
  } vec_t;

  vec_t        tbl [8];
  logic [15:0] pq [$];

  initial begin
    bit          r, saw_idle, found;
    int          run_at, busy_bad, mono_bad;
    int          pops, lows, bad, ones, got;
    int          pop_n [2];
    logic [15:0] pop_v [2];
    int          und_n, und_cnt, npop;
    logic [15:0] prev, prevc, nxt;

    tbl[0] = '{en: 0, n: 4,   busy: 0, ready: 0, lvl: 16'h0000};
    tbl[1] = '{en: 1, n: 1,   busy: 1, ready: 1, lvl: 16'h0040};
    tbl[2] = '{en: 1, n: 127, busy: 1, ready: 1, lvl: 16'h2000};
    tbl[3] = '{en: 0, n: 64,  busy: 1, ready: 1, lvl: 16'h1000};
    tbl[4] = '{en: 1, n: 1,   busy: 1, ready: 1, lvl: 16'h1040};
    tbl[5] = '{en: 1, n: 447, busy: 1, ready: 1, lvl: 16'h8000};
    tbl[6] = '{en: 0, n: 1,   busy: 1, ready: 1, lvl: 16'h7fc0};
    tbl[7] = '{en: 0, n: 511, busy: 0, ready: 0, lvl: 16'h0000};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      en[i]  = 1'b0;
      val[i] = 1'b0;
      smp[i] = 16'h0;
      m_reset(i);
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst pdm", i, pdm[i], 0);
      chk("rst busy", i, bsy[i], 0);
      chk("rst ready", i, rdy[i], 0);
      chk("rst underrun", i, und[i], 0);
      chk("rst lvl", i, lvl_p[i], 0);
      chk("rst cur", i, cur_p[i], 16'h8000);
    end
    cyc();
    cyc();
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // ramp table, including a reversal at 0x2000
    saw_idle = 1'b0;
    for (int v = 0; v < 8; v++) begin
      en[0] = tbl[v].en;
      for (int k = 0; k < tbl[v].n; k++) begin
        cyc();
        if (v >= 3 && v <= 5 && !bsy[0]) saw_idle = 1'b1;
      end
      chk("tbl busy", v, bsy[0], tbl[v].busy);
      chk("tbl ready", v, rdy[0], tbl[v].ready);
      chk("tbl lvl", v, lvl_p[0], tbl[v].lvl);
    end
    chk("reversal idle visit", 0, saw_idle, 0);

    // soft start from idle
    en[0]    = 1'b1;
    prev     = 16'h0;
    run_at   = 0;
    busy_bad = 0;
    mono_bad = 0;
    for (int k = 1; k <= 600 && run_at == 0; k++) begin
      cyc();
      if (!bsy[0]) busy_bad++;
      if (lvl_p[0] < prev) mono_bad++;
      prev = lvl_p[0];
      if (lvl_p[0] == 16'h8000) run_at = k;
    end
    chk("softstart ticks", 0, run_at, 512);
    chk("softstart busy", 0, busy_bad, 0);
    chk("softstart monotonic", 0, mono_bad, 0);

    // backpressure with valid held high
    val[0] = 1'b1;
    nxt    = 16'h1000;
    smp[0] = nxt;
    pops   = 0;
    lows   = 0;
    bad    = 0;
    prevc  = cur_p[0];
    pq.delete();
    for (int k = 0; k < 1100; k++) begin
      r = rdy[0];
      cyc();
      if (r) begin
        pq.push_back(smp[0]);
        nxt    = nxt + 16'd1;
        smp[0] = nxt;
      end
      if (!rdy[0]) lows++;
      if (cur_p[0] != prevc) begin
        pops++;
        if (pq.size() == 0) bad++;
        else if (pq.pop_front() != cur_p[0]) bad++;
        prevc = cur_p[0];
      end
    end
    chk("bp pops", 0, pops, 4);
    chk("bp order", 0, bad, 0);
    chk("bp ready drop", 0, lows > 0, 1);
    chk("bp pending", 0, pq.size(), 2);

    // density with constant 0x4000 kept fed
    smp[0] = 16'h4000;
    found  = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      cyc();
      if (cur_p[0] == 16'h4000) found = 1'b1;
    end
    chk("density first pop", 0, found, 1);
    ones = 0;
    for (int k = 0; k < 65536; k++) begin
      cyc();
      if (pdm[0]) ones++;
    end
    chk("density ones", 0, ones, 16384);

    // randomized traffic on both instances
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 299) == 0) en[0] = ~en[0];
      if ($urandom_range(0, 39) == 0) en[1] = ~en[1];
      for (int i = 0; i < 2; i++) begin
        val[i] = 1'($urandom_range(0, 1));
        smp[i] = 16'($urandom);
      end
      cyc();
    end

    // underrun sequence on the SAMPLE_DIV=4 instance
    en[0]  = 1'b0;
    val[0] = 1'b0;
    val[1] = 1'b0;
    en[1]  = 1'b0;
    rst[1] = 1'b1;
    cyc();
    cyc();
    rst[1] = 1'b0;
    en[1]  = 1'b1;
    val[1] = 1'b1;
    smp[1] = 16'ha000;
    got    = 0;
    for (int k = 0; k < 30 && got < 2; k++) begin
      r = rdy[1];
      cyc();
      if (r) begin
        got++;
        smp[1] = 16'hc000;
      end
    end
    val[1] = 1'b0;
    chk("u1 pushes", 1, got, 2);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      cyc();
      if (lvl_p[1] == 16'h8000) found = 1'b1;
    end
    chk("u1 run entry", 1, found, 1);
    npop    = 0;
    und_n   = 0;
    und_cnt = 0;
    prevc   = cur_p[1];
    pop_n[0] = 0;
    pop_n[1] = 0;
    pop_v[0] = 16'h0;
    pop_v[1] = 16'h0;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      if (cur_p[1] != prevc) begin
        if (npop < 2) begin
          pop_n[npop] = n;
          pop_v[npop] = cur_p[1];
        end
        npop++;
        prevc = cur_p[1];
      end
      if (und[1]) begin
        und_cnt++;
        und_n = n;
      end
    end
    chk("u1 pop count", 1, npop, 2);
    chk("u1 pop1 cycle", 1, pop_n[0], 12);
    chk("u1 pop1 value", 1, pop_v[0], 16'ha000);
    chk("u1 pop2 cycle", 1, pop_n[1], 24);
    chk("u1 pop2 value", 1, pop_v[1], 16'hc000);
    chk("u1 underrun count", 1, und_cnt, 1);
    chk("u1 underrun cycle", 1, und_n, 35);
    chk("u1 cur held", 1, cur_p[1], 16'hc000);

    // asynchronous reset between edges while running
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc();
      if (pdm[1]) found = 1'b1;
    end
    chk("u1 pdm high before reset", 1, found, 1);
    #3;
    rst[1] = 1'b1;
    #1;
    chk("async pdm", 1, pdm[1], 0);
    chk("async busy", 1, bsy[1], 0);
    chk("async ready", 1, rdy[1], 0);
    chk("async underrun", 1, und[1], 0);
    chk("async lvl", 1, lvl_p[1], 0);
    chk("async cur", 1, cur_p[1], 16'h8000);
    m_reset(1);
    cyc();
    cyc();
    rst[1] = 1'b0;
    for (int k = 0; k < 30; k++) cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
